// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_nbit_comb.sv
// rtl/alu_nbit_comb.sv - combinational WIDTH-bit datapath for the single-cycle ops
module alu_nbit_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic             binv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             ovf_raw;
    logic             slt;

    // One shared adder; SUB and SLT invert B and inject the +1 as carry-in
    always_comb begin
        binv     = (op == OP_SUB) || (op == OP_SLT);
        b_eff    = binv ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, binv};
        sum      = sum_full[WIDTH-1:0];
        ovf_raw  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        slt      = sum[WIDTH-1] ^ ovf_raw;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result   = sum;
                carry    = sum_full[WIDTH];
                overflow = ovf_raw;
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered ALU with valid/ready handshake and shift-add multiply
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_hi,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow
);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [WIDTH-1:0]   comb_result;
    logic               comb_carry;
    logic               comb_ovf;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [CNT_W-1:0]   cnt;

    alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (A),
        .b        (B),
        .op       (Operation),
        .result   (comb_result),
        .carry    (comb_carry),
        .overflow (comb_ovf)
    );

    assign accept   = in_valid && in_ready;
    assign is_mul   = (Operation == OP_MUL);
    assign mul_last = (state == ST_MUL) && (cnt == CNT_W'(WIDTH-1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state: a new accept always wins, so HOLD can reissue without a bubble
    always_comb begin
        state_next = state;
        if (accept)
            state_next = is_mul ? ST_MUL : ST_HOLD;
        else if (state == ST_HOLD && out_ready)
            state_next = ST_IDLE;
        else if (mul_last)
            state_next = ST_HOLD;
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
        out_valid = (state == ST_HOLD);
    end

    // One multiply iteration: conditional add into the upper half, then shift right with carry
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Result/flag registers and multiply engine; the last iteration writes the product directly
    always_ff @(posedge clk) begin
        if (reset) begin
            Result    <= '0;
            Result_hi <= '0;
            Zero      <= 1'b0;
            CarryOut  <= 1'b0;
            Overflow  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (accept && !is_mul) begin
            Result    <= comb_result;
            Result_hi <= '0;
            Zero      <= (comb_result == '0);
            CarryOut  <= comb_carry;
            Overflow  <= comb_ovf;
        end else if (accept && is_mul) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == ST_MUL) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (mul_last) begin
                Result    <= acc_next[WIDTH-1:0];
                Result_hi <= acc_next[2*WIDTH-1:WIDTH];
                Zero      <= (acc_next[WIDTH-1:0] == '0);
                CarryOut  <= 1'b0;
                Overflow  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - self-checking bench for alu_nbit_seq at WIDTH = 8
module tb_alu_nbit_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   Operation = 3'b000;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Result;
    logic [W-1:0] Result_hi;
    logic         Zero;
    logic         CarryOut;
    logic         Overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q[$];

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Result_hi (Result_hi),
        .Zero      (Zero),
        .CarryOut  (CarryOut),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        e = '0;
        case (op)
            OP_AND:  e.lo = a & b;
            OP_OR:   e.lo = a | b;
            OP_NAND: e.lo = ~(a & b);
            OP_NOR:  e.lo = ~(a | b);
            OP_ADD: begin
                r    = ua + ub;
                e.lo = r[7:0];
                e.c  = (r > 255);
                e.v  = (sa + sb > 127) || (sa + sb < -128);
            end
            OP_SUB: begin
                r    = ua - ub;
                e.lo = r[7:0];
                e.c  = (ua >= ub);
                e.v  = (sa - sb > 127) || (sa - sb < -128);
            end
            OP_SLT:  e.lo = (sa < sb) ? 8'd1 : 8'd0;
            default: begin
                r    = ua * ub;
                e.lo = r[7:0];
                e.hi = r[15:8];
            end
        endcase
        e.z = (e.lo == 8'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard bookkeeping on the handshake edges; reset discards anything in flight
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(Operation, A, B));
        end
    end

    // Every cycle the output is valid it must equal the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                check("mon_unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                check("mon_result",    32'(Result),    32'(q[0].lo));
                check("mon_result_hi", 32'(Result_hi), 32'(q[0].hi));
                check("mon_zero",      32'(Zero),      32'(q[0].z));
                check("mon_carry",     32'(CarryOut),  32'(q[0].c));
                check("mon_overflow",  32'(Overflow),  32'(q[0].v));
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
        int n = 0;
        Operation = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc_cyc, output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("wait_valid_timeout", 32'(out_valid), 32'd1);
        lat = cyc - acc_cyc;
    endtask

    vec_t vecs[8] = '{
        '{OP_ADD,  8'hFF, 8'h01},
        '{OP_SUB,  8'h00, 8'h01},
        '{OP_SUB,  8'h80, 8'h01},
        '{OP_SLT,  8'h01, 8'h80},
        '{OP_NAND, 8'hF0, 8'h3C},
        '{OP_MUL,  8'h00, 8'h37},
        '{OP_MUL,  8'h80, 8'h02},
        '{OP_OR,   8'h00, 8'h00}
    };

    initial begin
        int ac;
        int lat;
        int lows;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_result",    32'(Result),    32'd0);
        check("rst_result_hi", 32'(Result_hi), 32'd0);
        check("rst_zero",      32'(Zero),      32'd0);
        check("rst_flags",     32'({CarryOut, Overflow}), 32'd0);

        issue(OP_ADD, 8'h7F, 8'h01, ac);
        wait_valid(ac, lat);
        check("add_latency",  32'(lat), 32'd1);
        check("add_result",   32'(Result), 32'h80);
        check("add_flags_zcv", 32'({Zero, CarryOut, Overflow}), 32'b001);

        issue(OP_SUB, 8'h05, 8'h05, ac);
        wait_valid(ac, lat);
        check("sub_result",   32'(Result), 32'h00);
        check("sub_flags_zcv", 32'({Zero, CarryOut, Overflow}), 32'b110);

        issue(OP_SLT, 8'h80, 8'h01, ac);
        wait_valid(ac, lat);
        check("slt_result", 32'(Result), 32'h01);

        issue(OP_MUL, 8'hFF, 8'hFF, ac);
        lows = 0;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            if (!in_ready) lows++;
            @(negedge clk);
        end
        lat = cyc - ac;
        check("mul_latency",     32'(lat),  32'd9);
        check("mul_in_ready_lo", 32'(lows), 32'd8);
        check("mul_result",      32'(Result),    32'h01);
        check("mul_result_hi",   32'(Result_hi), 32'hFE);

        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_NOR, 8'h0F, 8'hF0, ac);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_result",   32'(Result),    32'h00);
            check("bp_zero",     32'(Zero),      32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(OP_AND, 8'hF0, 8'h3C, ac);
        check("b2b_latency", 32'(cyc - ac), 32'd1);
        check("b2b_valid",   32'(out_valid), 32'd1);
        check("b2b_result",  32'(Result),    32'h30);

        @(negedge clk);
        issue(OP_MUL, 8'h10, 8'h10, ac);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_result",    32'(Result),    32'd0);
        check("mrst_result_hi", 32'(Result_hi), 32'd0);
        @(negedge clk);
        issue(OP_OR, 8'h01, 8'h02, ac);
        wait_valid(ac, lat);
        check("or_result", 32'(Result), 32'h03);

        issue(OP_MUL, 8'h03, 8'h05, ac);
        A = 8'hFF;
        B = 8'hFF;
        wait_valid(ac, lat);
        check("mulhold_latency",   32'(lat),       32'd9);
        check("mulhold_result",    32'(Result),    32'h0F);
        check("mulhold_result_hi", 32'(Result_hi), 32'h00);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, ac);
            wait_valid(ac, lat);
            check("vec_latency", 32'(lat), (vecs[i].op == OP_MUL) ? 32'd9 : 32'd1);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
- Parametrised WIDTH-bit ALU with a registered result and a valid/ready handshake on both input and output.
- Extends the team's 1-bit ALU op set (AND/OR/ADD/NAND/NOR/SUB/SLT) with full-width status flags and an internal SUB path, so callers do not drive Binvert.
- Adds a multi-cycle unsigned shift-add multiply (MUL) on the previously unused opcode 101.
- Sits between the register-file read stage and writeback in the datapath.

Parameters:
- WIDTH, 32: operand and result width in bits; legal values are 2 and above.
- CNT_W, $clog2(WIDTH+1): width of the internal MUL iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  block accepts an operation this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Operation  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 101 MUL, 110 SUB, 111 SLT
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer takes the result this cycle
- Result  output  WIDTH  result; the low half of the product for MUL
- Result_hi  output  WIDTH  high half of the product for MUL; 0 for all other ops
- Zero  output  1  Result == 0
- CarryOut  output  1  carry out of the MSB for ADD/SUB; SUB carry = no borrow; 0 otherwise
- Overflow  output  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Reset, sampled on the clk edge: state = IDLE, out_valid = 0, Result = Result_hi = 0, Zero = 0, CarryOut = 0, Overflow = 0, MUL registers cleared.
- A reset asserted mid-MUL or in HOLD abandons the operation and discards the result.
- Accept condition: in_valid && in_ready on a rising edge. A, B and Operation are captured at that edge; later changes are ignored.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). This allows back-to-back issue when the consumer drains in the same cycle.
- State IDLE:
  - Accept of a single-cycle op: compute combinationally, register the outputs, go to HOLD. out_valid rises 1 cycle after accept.
  - Accept of MUL: load multiplicand = A, multiplier = B, acc = 0, cnt = 0, go to MUL.
- State MUL, one iteration per cycle:
  - If multiplier[0] = 1, add multiplicand into acc[2*WIDTH-1:WIDTH] with carry.
  - Shift {carry, acc} right by 1; shift the multiplier right by 1; cnt++.
  - When cnt reaches WIDTH-1 on the final iteration, register {Result_hi, Result} = acc, set the flags, and go to HOLD.
  - out_valid rises exactly WIDTH+1 cycles after accept.
  - in_ready = 0 throughout MUL.
- State HOLD:
  - out_valid = 1. Result and flags are stable while out_ready = 0.
  - If out_ready = 1 and in_valid = 0: go to IDLE, out_valid = 0 next cycle.
  - If out_ready = 1 and in_valid = 1: accept the new op (transitions as in IDLE). out_valid stays 1 for a single-cycle op, or drops during MUL.
- Arithmetic:
  - SUB = A + ~B + 1.
  - Overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the post-invert B.
  - SLT = signed A < B, computed as sub[MSB] XOR sub_overflow. Result = {0…, slt}; CarryOut = Overflow = 0.
  - Logic ops are bitwise over WIDTH.
  - MUL is unsigned with the full 2*WIDTH product. Zero reflects Result only.
- Every flag is registered together with Result in the same cycle.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_AND…OP_SLT, plus OP_MUL = 3'b101.
  - State encoding IDLE/MUL/HOLD (2-bit).
- Sub-module alu_nbit_comb: purely combinational WIDTH-bit datapath for the single-cycle ops. Outputs result, carry, overflow.
- alu_nbit_seq wraps alu_nbit_comb and adds the FSM, the handshake and the MUL engine.

Test Plan (WIDTH = 8):
- ADD 0x7F + 0x01, out_ready = 1 -> 1 cycle later out_valid = 1, Result = 0x80, Overflow = 1, CarryOut = 0, Zero = 0.
- SUB 0x05 - 0x05 -> Result = 0x00, Zero = 1, CarryOut = 1, Overflow = 0. Then SLT 0x80, 0x01 -> Result = 0x01.
- MUL 0xFF * 0xFF -> in_ready = 0 for 8 cycles; out_valid exactly 9 cycles after accept; Result = 0x01, Result_hi = 0xFE.
- Backpressure:
  - NOR 0x0F, 0xF0 with out_ready = 0 for 5 cycles -> Result = 0x00, Zero = 1, held stable; in_ready = 0.
  - Raising out_ready with in_valid = 1 (AND 0xF0, 0x3C) -> next cycle Result = 0x30 with no bubble.
- Reset asserted on cycle 4 of MUL 0x10 * 0x10 -> next cycle out_valid = 0, in_ready = 1, Result = Result_hi = 0. A subsequent OR 0x01, 0x02 -> Result = 0x03.
- Operand change after accept: MUL 0x03 * 0x05, then A/B driven to 0xFF during MUL -> Result = 0x0F, Result_hi = 0x00.
